dnn_argmax_fix: RTL and testbench
=================================

DNN_ARGMAX_FIX -- requirements
Module: dnn_argmax_fix

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each signed class score.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of each per-class and total prediction counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse from the upstream inference stage's done.
REQ-006 SHALL have port reset, input, 1, synchronous active-high soft clear.
REQ-007 SHALL have port in_vec, input, signed [DATA_WIDTH-1:0] x10, upstream class scores (out[9:0]).
REQ-008 SHALL have port busy, output, 1, high in SCAN and DONE states.
REQ-009 SHALL have port done, output, 1, one-cycle result-valid pulse.
REQ-010 SHALL have port digit, output, unsigned [3:0], winning class index 0..9.
REQ-011 SHALL have port max_val, output, signed [DATA_WIDTH-1:0], winning score.
REQ-012 SHALL have port margin, output, unsigned [DATA_WIDTH:0], winning score minus runner-up score.
REQ-013 SHALL have port class_cnt, output, unsigned [CNT_WIDTH-1:0] x10, predictions per class.
REQ-014 SHALL have port total_cnt, output, unsigned [CNT_WIDTH-1:0], total predictions.

Function
REQ-015 FSM SHALL have states IDLE, SCAN, DONE; IDLE->SCAN on start; SCAN->DONE after idx 9 is processed; DONE->IDLE unconditionally after one cycle.
REQ-016 On the edge sampling start=1 in IDLE, the block SHALL copy in_vec into an internal shadow array and clear the index counter to 0; later in_vec changes SHALL NOT affect the result.
REQ-017 SCAN SHALL process one shadow element per cycle, idx 0..9, over exactly 10 edges.
REQ-018 At idx 0 the block SHALL load best=v0, best_idx=0, second=-2^(DATA_WIDTH-1).
REQ-019 At idx>0, if v>best (signed): second<=best, best<=v, best_idx<=idx; else if v>second: second<=v; else no change.
REQ-020 Ties SHALL resolve to the lowest index; equal top scores SHALL yield margin 0.
REQ-021 On the SCAN->DONE edge, digit, max_val and margin (best-second, computed at DATA_WIDTH+1 bits, never negative) SHALL be registered and then held until the next result or clear.
REQ-022 On the same edge, class_cnt[best_idx] and total_cnt SHALL each increment by 1, saturating at all-ones.
REQ-023 done SHALL be high exactly during the DONE-state cycle, i.e. 11 cycles after the start-sampling edge; back-to-back start is accepted the cycle after done.
REQ-024 start while busy SHALL be ignored, with no queuing.
REQ-025 reset=1 SHALL, at the next edge, force IDLE, deassert done and busy, and zero digit, max_val, margin, all class_cnt and total_cnt; reset SHALL take precedence over start and over the DONE-edge update.
REQ-026 Reset mid-SCAN SHALL discard the partial result without incrementing any counter.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, with busy=0, done=0, digit=0, max_val=0, margin=0, all class_cnt=0, total_cnt=0.
REQ-028 Release of rst SHALL take effect at the first rising clk edge with rst=1; no output SHALL glitch during release.

Verification
REQ-029 in_vec={-5,3,120,7,0,-128,10,2,1,4} (idx0..9), start pulse -> done 11 cycles later, digit=2, max_val=120, margin=110, class_cnt[2]=1, total_cnt=1.
REQ-030 All scores=-128 -> digit=0, max_val=-128, margin=0; idx3=idx7=50, others 0 -> digit=3, margin=0.
REQ-031 idx9=127, idx0=-128, others -128 -> digit=9, margin=255, confirming the 9-bit margin has no overflow.
REQ-032 start re-pulsed during SCAN and in_vec changed after capture -> single done, result from the captured vector; then start the cycle after done -> second done 11 cycles later, total_cnt=2.
REQ-033 reset asserted at SCAN idx 5 -> IDLE next edge, no done, counters=0; reset coincident with start in IDLE -> stays IDLE.
REQ-034 Preload a class counter to 0xFFFF via 65535 runs (or force) -> further win keeps 0xFFFF; rst low mid-SCAN -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/dnn_argmax_fix.sv
// Argmax over ten signed class scores captured on start, with winner/runner-up margin
// and saturating per-class and total prediction counters.
module dnn_argmax_fix #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] in_vec [10],
    output logic                         busy,
    output logic                         done,
    output logic        [3:0]            digit,
    output logic signed [DATA_WIDTH-1:0] max_val,
    output logic        [DATA_WIDTH:0]   margin,
    output logic        [CNT_WIDTH-1:0]  class_cnt [10],
    output logic        [CNT_WIDTH-1:0]  total_cnt
);

    localparam logic signed [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic        [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic        [3:0]            LAST_IDX  = 4'd9;

    // One-hot so busy and done each decode from a single flop and cannot glitch.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        SCAN = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0] shadow [10];
    logic        [3:0]            idx;
    logic signed [DATA_WIDTH-1:0] best, second;
    logic        [3:0]            best_idx;

    logic signed [DATA_WIDTH-1:0] cur, nxt_best, nxt_second;
    logic        [3:0]            nxt_idx;
    logic        [DATA_WIDTH:0]   nxt_margin;
    logic                         capture;

    assign busy    = ~state_q[0];
    assign done    = state_q[2];
    assign capture = (state_q == IDLE) && start && !reset;
    assign cur     = shadow[idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (reset) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = SCAN;
                SCAN:    if (idx == LAST_IDX) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Strict greater-than keeps the lowest index on ties; an equal top score
    // falls through to the runner-up slot, which yields margin 0.
    always_comb begin
        nxt_best   = best;
        nxt_second = second;
        nxt_idx    = best_idx;
        if (idx == 4'd0) begin
            nxt_best   = cur;
            nxt_second = MIN_SCORE;
            nxt_idx    = 4'd0;
        end else if (cur > best) begin
            nxt_second = best;
            nxt_best   = cur;
            nxt_idx    = idx;
        end else if (cur > second) begin
            nxt_second = cur;
        end
        nxt_margin = {nxt_best[DATA_WIDTH-1], nxt_best} - {nxt_second[DATA_WIDTH-1], nxt_second};
    end

    // NOTE: the shadow array is pure datapath, always written before it is read,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture) shadow <= in_vec;
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= '0;
            best      <= '0;
            second    <= '0;
            best_idx  <= '0;
            digit     <= '0;
            max_val   <= '0;
            margin    <= '0;
            total_cnt <= '0;
            for (int i = 0; i < 10; i++) class_cnt[i] <= '0;
        end else if (reset) begin
            idx       <= '0;
            digit     <= '0;
            max_val   <= '0;
            margin    <= '0;
            total_cnt <= '0;
            for (int i = 0; i < 10; i++) class_cnt[i] <= '0;
        end else if (capture) begin
            idx <= '0;
        end else if (state_q == SCAN) begin
            best     <= nxt_best;
            second   <= nxt_second;
            best_idx <= nxt_idx;
            idx      <= idx + 4'd1;
            if (idx == LAST_IDX) begin
                digit   <= nxt_idx;
                max_val <= nxt_best;
                margin  <= nxt_margin;
                if (total_cnt != '1) total_cnt <= total_cnt + CNT_ONE;
                for (int i = 0; i < 10; i++) begin
                    if (nxt_idx == 4'(i) && class_cnt[i] != '1)
                        class_cnt[i] <= class_cnt[i] + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_dnn_argmax_fix.sv
// Scoreboard bench for dnn_argmax_fix: stimulus pushes predicted results, a monitor
// pops and compares on every done; a narrow-counter instance exercises saturation.
module tb_dnn_argmax_fix;

    localparam int DW  = 8;
    localparam int CW  = 16;
    localparam int SCW = 4;

    typedef logic signed [DW-1:0] vec_t [10];
    typedef struct {
        int digit;
        int max_val;
        int margin;
        int total;
        int cls [10];
        int s_total;
        int s_cls [10];
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic reset = 1'b0;
    vec_t in_vec;

    logic                 busy, done;
    logic [3:0]           digit;
    logic signed [DW-1:0] max_val;
    logic [DW:0]          margin;
    logic [CW-1:0]        class_cnt [10];
    logic [CW-1:0]        total_cnt;

    logic                 s_busy, s_done;
    logic [3:0]           s_digit;
    logic signed [DW-1:0] s_max_val;
    logic [DW:0]          s_margin;
    logic [SCW-1:0]       s_class_cnt [10];
    logic [SCW-1:0]       s_total_cnt;

    int   checks = 0;
    int   failures = 0;
    exp_t sb [$];
    int   cnt [10];
    int   total = 0;

    always #5 clk = ~clk;

    dnn_argmax_fix #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .reset(reset), .in_vec(in_vec),
        .busy(busy), .done(done), .digit(digit), .max_val(max_val), .margin(margin),
        .class_cnt(class_cnt), .total_cnt(total_cnt)
    );

    dnn_argmax_fix #(.DATA_WIDTH(DW), .CNT_WIDTH(SCW)) u_sat (
        .clk(clk), .rst(rst), .start(start), .reset(reset), .in_vec(in_vec),
        .busy(s_busy), .done(s_done), .digit(s_digit), .max_val(s_max_val), .margin(s_margin),
        .class_cnt(s_class_cnt), .total_cnt(s_total_cnt)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 10; i++) cnt[i] = 0;
        total = 0;
    endtask

    // Reference: winner is the first index holding the maximum; runner-up is the
    // largest of the remaining nine scores.
    task automatic push_expected(input vec_t v);
        exp_t e;
        int   best, second, bi;
        best = v[0];
        bi   = 0;
        for (int i = 1; i < 10; i++) begin
            if (int'(v[i]) > best) begin
                best = v[i];
                bi   = i;
            end
        end
        second = -100000;
        for (int j = 0; j < 10; j++) begin
            if (j != bi && int'(v[j]) > second) second = v[j];
        end
        cnt[bi]++;
        total++;
        e.digit   = bi;
        e.max_val = best;
        e.margin  = best - second;
        e.total   = min_int(total, (1 << CW) - 1);
        e.s_total = min_int(total, (1 << SCW) - 1);
        for (int i = 0; i < 10; i++) begin
            e.cls[i]   = min_int(cnt[i], (1 << CW) - 1);
            e.s_cls[i] = min_int(cnt[i], (1 << SCW) - 1);
        end
        sb.push_back(e);
    endtask

    function automatic vec_t from_int(input int d [10]);
        vec_t v;
        int   t;
        for (int i = 0; i < 10; i++) begin
            t    = d[i];
            v[i] = t[DW-1:0];
        end
        return v;
    endfunction

    function automatic vec_t rand_vec(input bit narrow);
        int d [10];
        for (int i = 0; i < 10; i++)
            d[i] = narrow ? int'($urandom_range(0, 4)) - 2 : int'($urandom_range(0, 255)) - 128;
        return from_int(d);
    endfunction

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_digit"}, digit, 0);
        check({tag, "_max_val"}, max_val, 0);
        check({tag, "_margin"}, margin, 0);
        check({tag, "_total"}, total_cnt, 0);
        check({tag, "_sat_total"}, s_total_cnt, 0);
        for (int i = 0; i < 10; i++) check($sformatf("%s_class_cnt[%0d]", tag, i), class_cnt[i], 0);
    endtask

    // mode 0: normal run; 1: re-pulse start and change in_vec mid-scan;
    // 2: soft clear at idx 5; 3: async reset mid-scan.
    task automatic issue(input vec_t v, input int mode);
        int lat;
        @(negedge clk);
        in_vec = v;
        start  = 1'b1;
        if (mode < 2) push_expected(v);
        @(posedge clk);
        #1 start = 1'b0;
        if (mode == 2) begin
            repeat (6) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            clear_model();
            check_cleared("soft_clear_mid_scan");
            repeat (15) @(negedge clk);
        end else if (mode == 3) begin
            repeat (5) @(negedge clk);
            #2 rst = 1'b0;
            #1 check_cleared("async_reset_mid_scan");
            clear_model();
            @(negedge clk);
            rst = 1'b1;
            repeat (15) @(negedge clk);
        end else begin
            lat = 0;
            for (int k = 1; k <= 30; k++) begin
                @(negedge clk);
                if (done) begin
                    lat = k;
                    break;
                end
                if (mode == 1 && k == 3) begin
                    start  = 1'b1;
                    in_vec = rand_vec(1'b0);
                end
                if (mode == 1 && k == 4) start = 1'b0;
            end
            check("start_to_done_latency", lat, 11);
        end
    endtask

    // Monitor: every done pops one prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    e = sb.pop_front();
                    check("digit", digit, e.digit);
                    check("max_val", max_val, e.max_val);
                    check("margin", margin, e.margin);
                    check("total_cnt", total_cnt, e.total);
                    check("busy_in_done", busy, 1);
                    check("sat_done", s_done, 1);
                    check("sat_total_cnt", s_total_cnt, e.s_total);
                    for (int i = 0; i < 10; i++) begin
                        check($sformatf("class_cnt[%0d]", i), class_cnt[i], e.cls[i]);
                        check($sformatf("sat_class_cnt[%0d]", i), s_class_cnt[i], e.s_cls[i]);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d_main [10] = '{-5, 3, 120, 7, 0, -128, 10, 2, 1, 4};
        int d_min  [10] = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
        int d_tie  [10] = '{0, 0, 0, 50, 0, 0, 0, 50, 0, 0};
        int d_wide [10] = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, 127};

        for (int i = 0; i < 10; i++) in_vec[i] = '0;
        clear_model();

        repeat (3) @(negedge clk);
        check_cleared("in_reset");
        rst = 1'b1;
        @(negedge clk);
        check_cleared("after_release");

        issue(from_int(d_main), 0);
        issue(from_int(d_min), 0);
        issue(from_int(d_tie), 0);
        issue(from_int(d_wide), 0);

        // Capture isolation, then a back-to-back run the cycle after done.
        issue(rand_vec(1'b0), 1);
        issue(rand_vec(1'b0), 0);

        for (int n = 0; n < 40; n++) issue(rand_vec(n[0]), 0);

        issue(rand_vec(1'b0), 2);

        // Soft clear coincident with start in IDLE: must stay idle.
        @(negedge clk);
        in_vec = rand_vec(1'b0);
        start  = 1'b1;
        reset  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        reset  = 1'b0;
        check("clear_with_start_busy", busy, 0);
        repeat (15) @(negedge clk);
        check("clear_with_start_total", total_cnt, 0);

        issue(rand_vec(1'b1), 0);
        issue(rand_vec(1'b0), 0);
        issue(rand_vec(1'b0), 3);
        issue(from_int(d_main), 0);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
